// File: rtl/lm07_read_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : lm07_read_if                                           |
// | Description : 3-wire SPI bus between the LM07 reader and the sensor. |
// |               CS and SCK come from the master, SIO from the sensor.  |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
interface lm07_read_if;
  logic CS;
  logic SCK;
  logic SIO;

  modport master (output CS, output SCK, input SIO);
  modport slave  (input CS, input SCK, output SIO);
endinterface
`default_nettype wire

// File: rtl/lm07_read.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : lm07_read                                              |
// | Description : Reads 16-bit frames from an LM07 temperature sensor    |
// |               and shows the integer degrees on a 2-digit muxed       |
// |               7-segment display; raw temperature on a debug byte.    |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module lm07_read #(
  parameter int SCK_HALF     = 1,
  parameter int GAP_CYCLES   = 8,
  parameter int MUX_DIV_BITS = 4
) (
  input  wire logic       SYSCLK,
  input  wire logic       RSTN,      // active-high synchronous reset
  lm07_read_if.master     spi,
  output logic [1:0]      disp,
  output logic [7:0]      dataSeg,
  output logic [7:0]      dbugout
);

  localparam int HALF_W = (SCK_HALF > 1) ? $clog2(SCK_HALF) : 1;
  localparam int GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(SCK_HALF - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
  localparam logic [7:0]        SEG_MINUS = 8'h40;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [GAP_W-1:0]        gap_q, gap_d;
  logic [HALF_W-1:0]       half_q, half_d;
  logic [4:0]              edge_q, edge_d;     // SCK toggles within a frame
  logic                    cs_q, cs_d;
  logic                    sck_q, sck_d;
  logic [15:0]             shift_q, shift_d;
  logic [8:0]              temp_q, temp_d;     // frame[15:7], two's complement
  logic [MUX_DIV_BITS-1:0] mux_q, mux_d;
  logic [1:0]              disp_q, disp_d;
  logic [7:0]              seg_q, seg_d;

  logic [6:0]              val;
  logic [7:0]              seg_units;
  logic [7:0]              seg_tens;

  function automatic logic [7:0] seg7(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = 8'h3F;
      4'd1:    s = 8'h06;
      4'd2:    s = 8'h5B;
      4'd3:    s = 8'h4F;
      4'd4:    s = 8'h66;
      4'd5:    s = 8'h6D;
      4'd6:    s = 8'h7D;
      4'd7:    s = 8'h07;
      4'd8:    s = 8'h7F;
      4'd9:    s = 8'h6F;
      default: s = 8'h00;
    endcase
    return s;
  endfunction

  // Frame sequencer: gap timing, SCK generation, sampling and latch load.
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    half_d  = half_q;
    edge_d  = edge_q;
    cs_d    = cs_q;
    sck_d   = sck_q;
    shift_d = shift_q;
    temp_d  = temp_q;
    case (state_q)
      ST_IDLE: begin
        cs_d   = 1'b1;
        sck_d  = 1'b0;
        half_d = '0;
        edge_d = '0;
        if (gap_q == GAP_LAST) begin
          state_d = ST_SHIFT;
          cs_d    = 1'b0;
          gap_d   = '0;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      ST_SHIFT: begin
        cs_d = 1'b0;
        if (half_q == HALF_LAST) begin
          half_d = '0;
          sck_d  = ~sck_q;
          edge_d = edge_q + 5'd1;
          // SIO is stable here: the sensor only moves it on SCK falls.
          if (!sck_q) begin
            shift_d = {shift_q[14:0], spi.SIO};
          end
          // The 32nd toggle is the 16th falling edge: frame complete.
          if (sck_q && (edge_q == 5'd31)) begin
            state_d = ST_IDLE;
            cs_d    = 1'b1;
            sck_d   = 1'b0;
            temp_d  = shift_q[15:7];
          end
        end else begin
          half_d = half_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cs_d    = 1'b1;
        sck_d   = 1'b0;
      end
    endcase
  end

  // Digit decode and multiplexing; uses the next latch value so the
  // display changes on the same edge as the latch.
  always_comb begin
    mux_d     = mux_q + 1'b1;
    val       = (temp_d[7:0] > 8'd99) ? 7'd99 : temp_d[6:0];
    seg_units = seg7(4'(val % 7'd10));
    seg_tens  = seg7(4'(val / 7'd10));
    if (temp_d[8]) begin
      seg_units = SEG_MINUS;
      seg_tens  = SEG_MINUS;
    end
    if (mux_q[MUX_DIV_BITS-1]) begin
      disp_d = 2'b10;
      seg_d  = seg_tens;
    end else begin
      disp_d = 2'b01;
      seg_d  = seg_units;
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge SYSCLK) begin
    if (RSTN) begin
      state_q <= ST_IDLE;
      gap_q   <= '0;
      half_q  <= '0;
      edge_q  <= '0;
      cs_q    <= 1'b1;
      sck_q   <= 1'b0;
      shift_q <= '0;
      temp_q  <= '0;
      mux_q   <= '0;
      disp_q  <= 2'b00;
      seg_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      half_q  <= half_d;
      edge_q  <= edge_d;
      cs_q    <= cs_d;
      sck_q   <= sck_d;
      shift_q <= shift_d;
      temp_q  <= temp_d;
      mux_q   <= mux_d;
      disp_q  <= disp_d;
      seg_q   <= seg_d;
    end
  end

  assign spi.CS  = cs_q;
  assign spi.SCK = sck_q;
  assign disp    = disp_q;
  assign dataSeg = seg_q;
  assign dbugout = temp_q[7:0];

endmodule
`default_nettype wire

// File: tb/tb_lm07_read.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_lm07_read                                           |
// | Description : Self-checking bench for lm07_read with a sensor model  |
// |               and a frame-level display reference.                   |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module tb_lm07_read;
  localparam int SCK_HALF     = 1;
  localparam int GAP_CYCLES   = 8;
  localparam int MUX_DIV_BITS = 4;

  logic       SYSCLK = 1'b0;
  logic       RSTN   = 1'b1;
  logic [1:0] disp;
  logic [7:0] dataSeg;
  logic [7:0] dbugout;

  lm07_read_if spi ();

  lm07_read #(
    .SCK_HALF    (SCK_HALF),
    .GAP_CYCLES  (GAP_CYCLES),
    .MUX_DIV_BITS(MUX_DIV_BITS)
  ) dut (
    .SYSCLK (SYSCLK),
    .RSTN   (RSTN),
    .spi    (spi.master),
    .disp   (disp),
    .dataSeg(dataSeg),
    .dbugout(dbugout)
  );

  always #5 SYSCLK = ~SYSCLK;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] next_frame = 16'h0000;
  logic [15:0] sent_frame = 16'h0000;
  int          bp = 0;
  int          rises = 0;
  int          lowlen = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference display: segment code for one digit of a frame.
  function automatic logic [7:0] ref_seg(input logic [15:0] f, input bit tens);
    logic [7:0] tbl [10];
    int v;
    tbl = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};
    if (f[15]) return 8'h40;
    v = int'(f[14:7]);
    if (v > 99) v = 99;
    return tens ? tbl[v / 10] : tbl[v % 10];
  endfunction

  // Sensor model: MSB on CS fall, next bit on each SCK fall, junk when idle.
  initial spi.SIO = 1'b0;
  always @(negedge spi.CS) begin
    sent_frame = next_frame;
    bp         = 15;
    spi.SIO    = sent_frame[15];
  end
  always @(negedge spi.SCK) begin
    if (spi.CS === 1'b0 && bp > 0) begin
      bp--;
      spi.SIO = sent_frame[bp];
    end
  end
  always @(posedge spi.CS) spi.SIO = 1'($urandom);

  // Waveform and display monitor.
  logic        mon_rs;
  logic        pcs = 1'b1;
  logic        psck = 1'b0;
  logic [1:0]  pdisp = 2'b00;
  int          run = 0;
  logic [15:0] shown = 16'h0000;

  always @(posedge SYSCLK) begin
    mon_rs = RSTN;
    #1;
    if (mon_rs) begin
      shown = 16'h0000;
      run   = 0;
      chk("rst_disp", 32'(disp), 32'h0);
      chk("rst_seg", 32'(dataSeg), 32'h0);
    end else begin
      if (spi.CS !== pcs) chk("sck_low_at_cs_edge", 32'(spi.SCK), 32'h0);
      if (pcs === 1'b1 && spi.CS === 1'b0) begin
        rises  = 0;
        lowlen = 0;
      end
      if (spi.CS === 1'b0) begin
        lowlen++;
        if (psck === 1'b0 && spi.SCK === 1'b1) rises++;
      end
      if (pcs === 1'b0 && spi.CS === 1'b1) begin
        chk("sck_rises", 32'(rises), 32'd16);
        chk("cs_low_len", 32'(lowlen), 32'd32);
        shown = sent_frame;
      end
      if (disp === 2'b01)      chk("seg_units", 32'(dataSeg), 32'(ref_seg(shown, 1'b0)));
      else if (disp === 2'b10) chk("seg_tens", 32'(dataSeg), 32'(ref_seg(shown, 1'b1)));
      else                     chk("disp_onehot", 32'(disp), 32'h1);
      if (disp !== pdisp) begin
        if (pdisp !== 2'b00) chk("mux_run", 32'(run), 32'(2 ** (MUX_DIV_BITS - 1)));
        run = 1;
      end else begin
        run++;
      end
    end
    pcs   = spi.CS;
    psck  = spi.SCK;
    pdisp = disp;
  end

  task automatic step();
    @(posedge SYSCLK);
    #2;
  endtask

  task automatic do_frame(input logic [15:0] f, input int gap_exp);
    int n;
    next_frame = f;
    n = 0;
    while (spi.CS === 1'b1 && n < 200) begin step(); n++; end
    chk("gap_len", 32'(n), 32'(gap_exp));
    n = 0;
    while (spi.CS === 1'b0 && n < 200) begin step(); n++; end
    chk("frame_len", 32'(n), 32'd32);
    chk("dbugout", 32'(dbugout), 32'(f[14:7]));
  endtask

  initial begin
    int n;
    logic [15:0] f;
    RSTN = 1'b1;
    repeat (3) step();
    chk("rst_cs", 32'(spi.CS), 32'h1);
    chk("rst_sck", 32'(spi.SCK), 32'h0);
    chk("rst_dbug", 32'(dbugout), 32'h0);

    RSTN = 1'b0;
    step();
    chk("first_disp", 32'(disp), 32'h1);
    chk("first_seg", 32'(dataSeg), 32'h3F);
    chk("first_cs", 32'(spi.CS), 32'h1);

    do_frame(16'h0F00, GAP_CYCLES - 1);
    do_frame(16'h4980, GAP_CYCLES);
    do_frame(16'hF380, GAP_CYCLES);
    for (int i = 0; i < 6; i++) begin
      f = 16'($urandom);
      if (i % 2 == 1) f[15] = 1'b0;
      do_frame(f, GAP_CYCLES);
    end

    // Reset in the middle of a frame at the 10th SCK rising edge.
    next_frame = 16'h0F00;
    n = 0;
    while (!(spi.CS === 1'b0 && rises == 10) && n < 200) begin step(); n++; end
    chk("reach_10th_rise", 32'(rises), 32'd10);
    RSTN = 1'b1;
    step();
    chk("midrst_cs", 32'(spi.CS), 32'h1);
    chk("midrst_sck", 32'(spi.SCK), 32'h0);
    chk("midrst_dbug", 32'(dbugout), 32'h0);
    RSTN = 1'b0;
    do_frame(16'h0F00, GAP_CYCLES);
    do_frame(16'(16'h1900 | 16'($urandom_range(0, 127))), GAP_CYCLES);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
